// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS symbol constants and scheduler state encoding
package tmds_pkg;
  localparam int TMDS_W = 10;
  localparam int PAIRS = 5;
  localparam logic [TMDS_W-1:0] CTRL_BLANK = 10'b1101010100;
  localparam logic [TMDS_W-1:0] CLOCK_PATTERN = 10'b0000011111;
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
endpackage

// File: rtl/tmds_pair_shifter.sv
// tmds_pair_shifter: holds one 10-bit symbol and emits its DDR pairs LSB first
module tmds_pair_shifter
  import tmds_pkg::*;
(
  input  logic              clk_shift,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [2:0]        sel,
  input  logic [TMDS_W-1:0] d,
  output logic [1:0]        q
);
  logic [TMDS_W-1:0] sym;
  always_ff @(posedge clk_shift) begin
    if (rst) begin
      sym <= '0;
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      sym <= d;
      q <= d[1:0];
    end else begin
      q <= sym[{sel, 1'b0} +: 2];
    end
  end
endmodule

// File: rtl/tmds_ddr_scheduler.sv
// tmds_ddr_scheduler: fetches TMDS triples per pixel and serialises them into DDR pairs
module tmds_ddr_scheduler
  import tmds_pkg::*;
#(
  parameter logic [TMDS_W-1:0] CTRL_BLANK_SYM = CTRL_BLANK,
  parameter logic [TMDS_W-1:0] CLOCK_SYM = CLOCK_PATTERN,
  parameter int CNT_W = 16
) (
  input  logic              clk_shift,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TMDS_W-1:0] in_red,
  input  logic [TMDS_W-1:0] in_green,
  input  logic [TMDS_W-1:0] in_blue,
  output logic [1:0]        out_clock,
  output logic [1:0]        out_red,
  output logic [1:0]        out_green,
  output logic [1:0]        out_blue,
  output logic [2:0]        phase,
  output logic              running,
  output logic              underflow,
  input  logic              underflow_clear,
  output logic [CNT_W-1:0]  underflow_count
);
  state_t state;
  logic last, uf, clr;
  logic [2:0] sel;
  assign last = (state == RUN) && (phase == 3'(PAIRS - 1));
  assign in_ready = (state == PRIME) || (last && enable);
  assign uf = in_ready && !in_valid;
  // lanes go quiet in IDLE/PRIME and right after a symbol that ends with enable low
  assign clr = (state == IDLE) || (last && !enable);
  assign sel = phase + 3'd1;
  tmds_pair_shifter u_clock (.clk_shift(clk_shift), .rst(rst), .clr(clr), .load(in_ready), .sel(sel), .d(CLOCK_SYM), .q(out_clock));
  tmds_pair_shifter u_red (.clk_shift(clk_shift), .rst(rst), .clr(clr), .load(in_ready), .sel(sel), .d(uf ? CTRL_BLANK_SYM : in_red), .q(out_red));
  tmds_pair_shifter u_green (.clk_shift(clk_shift), .rst(rst), .clr(clr), .load(in_ready), .sel(sel), .d(uf ? CTRL_BLANK_SYM : in_green), .q(out_green));
  tmds_pair_shifter u_blue (.clk_shift(clk_shift), .rst(rst), .clr(clr), .load(in_ready), .sel(sel), .d(uf ? CTRL_BLANK_SYM : in_blue), .q(out_blue));
  always_ff @(posedge clk_shift) begin
    if (rst) begin
      state <= IDLE;
      phase <= '0;
      running <= 1'b0;
      underflow <= 1'b0;
      underflow_count <= '0;
    end else begin
      case (state)
        IDLE: if (enable) state <= PRIME;
        PRIME: begin
          state <= RUN;
          phase <= '0;
          running <= 1'b1;
        end
        RUN: if (!last) phase <= phase + 3'd1;
          else begin
            phase <= '0;
            if (!enable) begin
              state <= IDLE;
              running <= 1'b0;
            end
          end
        default: state <= IDLE;
      endcase
      underflow <= (underflow && !underflow_clear) || uf;
      if (uf && !(&underflow_count)) underflow_count <= underflow_count + 1'b1;
    end
  end
endmodule
